// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - four-line request encoder with pending register and ack handshake
//
// Purpose: captures request pulses into a pending register and presents one
// granted index at a time on address1:address0 with valid. The presented
// grant is held until the consumer acks. At least one idle cycle follows
// each grant.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-high reset
//   req0..req3           request lines, sampled on every rising edge
//   ack                  consumer accepts the presented address
//   address0, address1   registered index of the granted request (address1 = MSB)
//   valid                registered; address holds a granted request
//
// Configuration: define REQUEST_ENCODER_RR_EN for round-robin selection.
// When it is undefined, selection is fixed priority with index 0 highest.
module request_encoder (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic ack,
  output logic address0,
  output logic address1,
  output logic valid
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] req_vec;
  logic [3:0] clr_mask;
  logic [1:0] sel;
  logic       grant;

  assign req_vec = {req3, req2, req1, req0};

`ifdef REQUEST_ENCODER_RR_EN
  logic [1:0] last_q;
  logic [1:0] cand;
  logic       found;

  // The search starts one past the last grant and wraps from 3 to 0.
  always_comb begin
    sel   = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && pending_q[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Reset value 3 makes the first search start at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 2'd3;
    end else if (grant) begin
      last_q <= sel;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest pending index selected.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel = 2'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    grant    = 1'b0;
    clr_mask = 4'b0000;
    case (state_q)
      IDLE: begin
        if (pending_q != 4'b0000) begin
          grant         = 1'b1;
          addr_d        = sel;
          clr_mask[sel] = 1'b1;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The clear is applied before the OR, so a request arriving at the same
    // edge as its own grant stays pending.
    pending_d = (pending_q & ~clr_mask) | req_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      addr_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign valid    = (state_q == PRESENT);
  assign address0 = addr_q[0];
  assign address1 = addr_q[1];

endmodule

// File: tb/tb_request_encoder.sv
// tb/tb_request_encoder.sv - self-checking bench for request_encoder
module tb_request_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_v = 4'b0000;
  logic       ack = 1'b0;
  logic       address0, address1, valid;

  int tests = 0;
  int fails = 0;

  // Reference state: the set of outstanding requests, whether a grant is
  // currently shown, the shown index and the last granted index.
  bit [3:0] m_pend;
  bit       m_valid;
  bit [1:0] m_addr;
  int       m_last;

  int grants[$];
  int n3;

  request_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req_v[0]),
    .req1     (req_v[1]),
    .req2     (req_v[2]),
    .req3     (req_v[3]),
    .ack      (ack),
    .address0 (address0),
    .address1 (address1),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend  = 4'b0000;
    m_valid = 1'b0;
    m_addr  = 2'b00;
    m_last  = 3;
  endtask

  function automatic int pick();
    int idx;
    idx = 0;
`ifdef REQUEST_ENCODER_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (m_pend[(m_last + k) % 4]) begin
        idx = (m_last + k) % 4;
        break;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (m_pend[k]) begin
        idx = k;
        break;
      end
    end
`endif
    return idx;
  endfunction

  task automatic model_edge();
    int idx;
    if (m_valid) begin
      if (ack) m_valid = 1'b0;
    end else if (m_pend != 4'b0000) begin
      idx         = pick();
      m_addr      = 2'(idx);
      m_valid     = 1'b1;
      m_pend[idx] = 1'b0;
      m_last      = idx;
    end
    m_pend = m_pend | req_v;
  endtask

  task automatic cmp(input string tag, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    cmp(tag, {valid, address1, address0}, {m_valid, m_addr});
  endtask

  initial begin
    model_reset();
    tick("rst0");
    tick("rst1");
    cmp("reset_state", {valid, address1, address0}, 3'b000);
    reset = 1'b0;

    // ack while idle with nothing pending is ignored
    ack = 1'b1;
    repeat (4) tick("ack_idle");
    cmp("ack_idle_const", {valid, address1, address0}, 3'b000);
    ack = 1'b0;

    // single pulse on req2, held presentation, then ack
    req_v = 4'b0100;
    tick("r2_e1");
    cmp("r2_not_yet", {valid, address1, address0}, 3'b000);
    req_v = 4'b0000;
    tick("r2_e2");
    cmp("r2_latency", {valid, address1, address0}, 3'b110);
    repeat (5) tick("r2_hold");
    cmp("r2_hold_const", {valid, address1, address0}, 3'b110);
    ack = 1'b1;
    tick("r2_ack");
    cmp("r2_ack_const", {valid, address1, address0}, 3'b010);
    ack = 1'b0;
    tick("idle_a");

    // prior grant of index 1, then all four at once with ack held high
    req_v = 4'b0010;
    tick("pre1_e1");
    req_v = 4'b0000;
    ack = 1'b1;
    tick("pre1_e2");
    tick("pre1_e3");
    req_v = 4'b1111;
    tick("all_e1");
    req_v = 4'b0000;
    grants.delete();
    for (int c = 0; c < 12; c++) begin
      tick("all_drain");
      if (valid) grants.push_back({address1, address0});
    end
    tests++;
    assert (grants.size() == 4) else begin
      fails++;
      $error("FAIL all_count observed=%0d expected=4", grants.size());
    end
    if (grants.size() == 4) begin
`ifdef REQUEST_ENCODER_RR_EN
      cmp("all_g0", 3'(grants[0]), 3'd2);
      cmp("all_g1", 3'(grants[1]), 3'd3);
      cmp("all_g2", 3'(grants[2]), 3'd0);
      cmp("all_g3", 3'(grants[3]), 3'd1);
`else
      cmp("all_g0", 3'(grants[0]), 3'd0);
      cmp("all_g1", 3'(grants[1]), 3'd1);
      cmp("all_g2", 3'(grants[2]), 3'd2);
      cmp("all_g3", 3'(grants[3]), 3'd3);
`endif
    end

    // req1 held high: set wins over clear, index 1 granted every 2 cycles
    req_v = 4'b0010;
    tick("hold1_e1");
    for (int c = 0; c < 8; c++) begin
      tick("hold1");
      cmp("hold1_rate", {valid, address1, address0}, (c % 2 == 0) ? 3'b101 : 3'b001);
    end
    req_v = 4'b0000;
    repeat (4) tick("hold1_drain");

    // req3 pulsed twice while index 0 is shown: one grant of 3
    ack = 1'b0;
    req_v = 4'b0001;
    tick("merge_e1");
    req_v = 4'b0000;
    tick("merge_e2");
    req_v = 4'b1000; tick("merge_p1");
    req_v = 4'b0000; tick("merge_g1");
    req_v = 4'b1000; tick("merge_p2");
    req_v = 4'b0000; tick("merge_g2");
    cmp("merge_stable", {valid, address1, address0}, 3'b100);
    ack = 1'b1;
    n3 = 0;
    for (int c = 0; c < 8; c++) begin
      tick("merge_drain");
      if (valid && {address1, address0} == 2'b11) n3++;
    end
    cmp("merge_once", 3'(n3), 3'd1);

    // asynchronous reset while presenting with 1 and 3 pending
    ack = 1'b0;
    req_v = 4'b0001;
    tick("rstp_e1");
    req_v = 4'b1010;
    tick("rstp_e2");
    req_v = 4'b0000;
    tick("rstp_e3");
    reset = 1'b1;
    #2;
    cmp("async_reset", {valid, address1, address0}, 3'b000);
    model_reset();
    tick("rstp_hold");
    reset = 1'b0;
    repeat (4) tick("rstp_after");
    cmp("rstp_no_regrant", {valid, address1, address0}, 3'b000);

    // request at the first edge after reset release is captured
    reset = 1'b1;
    tick("rst_again");
    reset = 1'b0;
    req_v = 4'b1000;
    tick("first_edge");
    req_v = 4'b0000;
    tick("first_edge_g");
    cmp("first_edge_const", {valid, address1, address0}, 3'b111);

    // random traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      req_v = 4'b0000;
      for (int b = 0; b < 4; b++) req_v[b] = ($urandom_range(0, 3) == 0);
      ack   = $urandom_range(0, 1);
      reset = ($urandom_range(0, 63) == 0);
      tick("random");
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
